// File: rtl/mem_cycle_arbiter_pkg.sv
// Shared types for the memory cycle arbiter: FSM states, cycle ownership
// and the DMA readiness rule.
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 12;
    localparam int DATA_W_DEF       = 16;
    localparam int LEN_W_DEF        = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    // A read transfer can always take a cycle; a write needs a device word.
    function automatic logic dma_is_ready(input logic dir_read, input logic wvalid);
        return dir_read | wvalid;
    endfunction

endpackage

// File: rtl/mem_cycle_arbiter_if.sv
// Bundle of CPU, DMA and memory-macro signals around the arbiter.
// slave = arbiter side, master = surrounding processor / memory side.
interface mem_cycle_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    // CPU control unit side
    logic              cpu_enable;
    logic              cpu_r_wb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    // DMA channel side
    logic              dma_start;
    logic              dma_r_wb;
    logic [ADDR_W-1:0] dma_base;
    logic [LEN_W-1:0]  dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_wvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_xfer;
    logic              dma_busy;
    logic              dma_done;
    // Memory macro side
    logic              mem_enable;
    logic              mem_r_wb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_enable, cpu_r_wb, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_start, dma_r_wb, dma_base, dma_len, dma_wdata, dma_wvalid,
        output dma_rdata, dma_xfer, dma_busy, dma_done,
        output mem_enable, mem_r_wb, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_enable, cpu_r_wb, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_start, dma_r_wb, dma_base, dma_len, dma_wdata, dma_wvalid,
        input  dma_rdata, dma_xfer, dma_busy, dma_done,
        input  mem_enable, mem_r_wb, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_cycle_arbiter_dma_addr_counter.sv
// DMA address register (wraps at the top of memory) and remaining-word
// down-counter. last_o flags that the next step empties the counter.
module dma_addr_counter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;

    // Load on transfer start, advance address / consume a word per DMA cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            addr_q <= base_i;
            cnt_q  <= len_i;
        end else if (step_i) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - LEN_W'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/mem_cycle_arbiter.sv
// Cycle-stealing arbiter between the CPU control unit and a block DMA
// channel on a single-port memory. The CPU owns any cycle it strobes unless
// the DMA has been denied STARVE_LIMIT times in a row, in which case the CPU
// is stalled for one cycle and the DMA takes it.
module mem_cycle_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LEN_W        = LEN_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 glb_clr,
    mem_cycle_arbiter_if.slave   bus
);

    localparam int              SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic              dir_q, dir_d;          // 1: memory-to-device
    logic [SW-1:0]     starve_q, starve_d;

    owner_e            owner;
    logic              forced;
    logic              dma_ready;
    logic              cnt_load;
    logic              cnt_last;
    logic [ADDR_W-1:0] dma_addr;

    assign dma_ready = dma_is_ready(dir_q, bus.dma_wvalid);
    assign cnt_load  = (state_q == IDLE) && bus.dma_start;

    dma_addr_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_cnt (
        .clk    (clk),
        .srst   (glb_clr),
        .load_i (cnt_load),
        .base_i (bus.dma_base),
        .len_i  (bus.dma_len),
        .step_i (owner == OWN_DMA),
        .addr_o (dma_addr),
        .last_o (cnt_last)
    );

    // State register: FSM state, latched direction, starvation counter
    always_ff @(posedge clk) begin
        if (glb_clr) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            starve_q <= starve_d;
        end
    end

    // Next-state: transfer sequencing and starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (bus.dma_start) begin
                    dir_d    = bus.dma_r_wb;
                    starve_d = '0;
                    state_d  = (bus.dma_len == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (owner == OWN_DMA) begin
                    // Any granted DMA cycle ends the run of denials
                    starve_d = '0;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end else if ((owner == OWN_CPU) && dma_ready && (starve_q < LIMIT)) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decide the cycle owner, then steer the memory and data buses
    always_comb begin
        owner  = OWN_NONE;
        forced = 1'b0;
        if (state_q == XFER) begin
            if (bus.cpu_enable) begin
                if ((starve_q >= LIMIT) && dma_ready) begin
                    owner  = OWN_DMA;
                    forced = 1'b1;
                end else begin
                    owner = OWN_CPU;
                end
            end else if (dma_ready) begin
                owner = OWN_DMA;
            end
        end else if (bus.cpu_enable) begin
            owner = OWN_CPU;
        end

        bus.mem_enable = 1'b0;
        bus.mem_r_wb   = 1'b1;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.cpu_rdata  = '0;
        bus.dma_rdata  = '0;
        case (owner)
            OWN_CPU: begin
                bus.mem_enable = 1'b1;
                bus.mem_r_wb   = bus.cpu_r_wb;
                bus.mem_addr   = bus.cpu_addr;
                bus.mem_wdata  = bus.cpu_wdata;
                bus.cpu_rdata  = bus.mem_rdata;
            end
            OWN_DMA: begin
                bus.mem_enable = 1'b1;
                bus.mem_r_wb   = dir_q;
                bus.mem_addr   = dma_addr;
                bus.mem_wdata  = dir_q ? '0 : bus.dma_wdata;
                bus.dma_rdata  = dir_q ? bus.mem_rdata : '0;
            end
            default: ;
        endcase

        bus.cpu_stall = forced;
        bus.dma_xfer  = (owner == OWN_DMA);
        bus.dma_busy  = (state_q == XFER);
        bus.dma_done  = (state_q == DONE);
    end

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// Directed bench for mem_cycle_arbiter with a behavioural 4096x16 memory
// (asynchronous read, write on the clock edge).
module tb_mem_cycle_arbiter;

    logic clk = 1'b0;
    logic glb_clr;
    always #5 clk = ~clk;

    mem_cycle_arbiter_if bus();

    mem_cycle_arbiter dut (
        .clk     (clk),
        .glb_clr (glb_clr),
        .bus     (bus.slave)
    );

    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.mem_enable && !bus.mem_r_wb) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_enable = 1'b0; bus.cpu_r_wb = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_start = 1'b0; bus.dma_r_wb = 1'b1; bus.dma_base = '0; bus.dma_len = '0;
        bus.dma_wdata = '0; bus.dma_wvalid = 1'b0;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b0; bus.cpu_addr = a; bus.cpu_wdata = d;
        step();
        bus.cpu_enable = 1'b0; bus.cpu_r_wb = 1'b1;
    endtask

    task automatic start_dma(input logic rd, input logic [11:0] base, input logic [7:0] len);
        bus.dma_start = 1'b1; bus.dma_r_wb = rd; bus.dma_base = base; bus.dma_len = len;
        step();
        bus.dma_start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        glb_clr = 1'b1;
        step(); step();
        vec_cnt++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.cpu_stall, bus.mem_enable} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.cpu_stall, bus.mem_enable});
        end
        bus.cpu_enable = 1'b1; bus.cpu_addr = 12'h123;
        #1;
        vec_cnt++;
        if ({bus.mem_enable, bus.mem_addr} !== {1'b1, 12'h123}) begin
            err_cnt++;
            $display("FAIL reset_cpu_passthrough: got %h expected %h", {bus.mem_enable, bus.mem_addr}, {1'b1, 12'h123});
        end
        glb_clr = 1'b0;
        bus.cpu_enable = 1'b0;
        step();
    endtask

    task automatic test_cpu_passthrough();
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b0; bus.cpu_addr = 12'h010; bus.cpu_wdata = 16'h1111;
        #1;
        vec_cnt++;
        if ({bus.mem_enable, bus.mem_r_wb, bus.mem_addr, bus.mem_wdata, bus.cpu_stall} !==
            {1'b1, 1'b0, 12'h010, 16'h1111, 1'b0}) begin
            err_cnt++;
            $display("FAIL cpu_write_path: got %h expected %h",
                     {bus.mem_enable, bus.mem_r_wb, bus.mem_addr, bus.mem_wdata, bus.cpu_stall},
                     {1'b1, 1'b0, 12'h010, 16'h1111, 1'b0});
        end
        step();
        cpu_write(12'h011, 16'h2222);
        cpu_write(12'h012, 16'h3333);
        cpu_write(12'hFFE, 16'hAAAA);
        cpu_write(12'hFFF, 16'hBBBB);
        cpu_write(12'h000, 16'hCCCC);
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b1; bus.cpu_addr = 12'h011;
        #1;
        vec_cnt++;
        if ({bus.cpu_rdata, bus.dma_rdata, bus.mem_r_wb} !== {16'h2222, 16'h0000, 1'b1}) begin
            err_cnt++;
            $display("FAIL cpu_read_path: got %h expected %h", {bus.cpu_rdata, bus.dma_rdata, bus.mem_r_wb},
                     {16'h2222, 16'h0000, 1'b1});
        end
        step();
        bus.cpu_enable = 1'b0;
    endtask

    task automatic test_idle_dma_read();
        logic [11:0] ea [3] = '{12'h010, 12'h011, 12'h012};
        logic [15:0] ed [3] = '{16'h1111, 16'h2222, 16'h3333};
        bus.cpu_enable = 1'b0;
        bus.dma_start = 1'b1; bus.dma_r_wb = 1'b1; bus.dma_base = 12'h010; bus.dma_len = 8'd3;
        #1;
        vec_cnt++;
        if ({bus.mem_enable, bus.dma_xfer, bus.dma_busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL rd_start_cycle: got %b expected 000", {bus.mem_enable, bus.dma_xfer, bus.dma_busy});
        end
        step();
        bus.dma_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if ({bus.dma_xfer, bus.dma_busy, bus.dma_done, bus.mem_r_wb, bus.mem_addr, bus.dma_rdata} !==
                {4'b1101, ea[i], ed[i]}) begin
                err_cnt++;
                $display("FAIL rd_word%0d: got %h expected %h", i,
                         {bus.dma_xfer, bus.dma_busy, bus.dma_done, bus.mem_r_wb, bus.mem_addr, bus.dma_rdata},
                         {4'b1101, ea[i], ed[i]});
            end
            step();
        end
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy, bus.dma_xfer} !== 3'b100) begin
            err_cnt++;
            $display("FAIL rd_done_pulse: got %b expected 100", {bus.dma_done, bus.dma_busy, bus.dma_xfer});
        end
        step();
        vec_cnt++;
        if (bus.dma_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rd_done_width: got %b expected 0", bus.dma_done);
        end
    endtask

    task automatic test_starvation();
        logic        ws;
        logic [11:0] wa;
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b1; bus.cpu_addr = 12'h200;
        bus.dma_wvalid = 1'b1; bus.dma_wdata = 16'hD000;
        start_dma(1'b0, 12'h300, 8'd2);
        for (int c = 1; c <= 10; c++) begin
            bus.dma_wdata = 16'hD000 + 16'(c);
            #1;
            ws = (c == 5) || (c == 10);
            wa = ws ? ((c == 10) ? 12'h301 : 12'h300) : 12'h200;
            vec_cnt++;
            if ({bus.cpu_stall, bus.dma_xfer, bus.dma_busy, bus.mem_r_wb, bus.mem_addr} !==
                {ws, ws, 1'b1, ~ws, wa}) begin
                err_cnt++;
                $display("FAIL starve_cycle%0d: got %h expected %h", c,
                         {bus.cpu_stall, bus.dma_xfer, bus.dma_busy, bus.mem_r_wb, bus.mem_addr},
                         {ws, ws, 1'b1, ~ws, wa});
            end
            step();
        end
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy, bus.cpu_stall} !== 3'b100) begin
            err_cnt++;
            $display("FAIL starve_done: got %b expected 100", {bus.dma_done, bus.dma_busy, bus.cpu_stall});
        end
        step();
        bus.dma_wvalid = 1'b0;
        bus.cpu_addr = 12'h300;
        #1;
        vec_cnt++;
        if (bus.cpu_rdata !== 16'hD005) begin
            err_cnt++;
            $display("FAIL starve_word0: got %h expected d005", bus.cpu_rdata);
        end
        bus.cpu_addr = 12'h301;
        #1;
        vec_cnt++;
        if (bus.cpu_rdata !== 16'hD00A) begin
            err_cnt++;
            $display("FAIL starve_word1: got %h expected d00a", bus.cpu_rdata);
        end
        step();
        bus.cpu_enable = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b1; bus.cpu_addr = 12'h050;
        bus.dma_wvalid = 1'b0; bus.dma_wdata = 16'h7777;
        start_dma(1'b0, 12'h400, 8'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            vec_cnt++;
            if ({bus.cpu_stall, bus.dma_xfer, bus.dma_busy, bus.mem_addr} !== {3'b001, 12'h050}) begin
                err_cnt++;
                $display("FAIL bp_hold%0d: got %h expected %h", c,
                         {bus.cpu_stall, bus.dma_xfer, bus.dma_busy, bus.mem_addr}, {3'b001, 12'h050});
            end
            step();
        end
        // Starve count must have stayed at 0: four more CPU cycles stall-free
        bus.dma_wvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++;
            if ({bus.cpu_stall, bus.dma_xfer} !== 2'b00) begin
                err_cnt++;
                $display("FAIL bp_cpu%0d: got %b expected 00", c, {bus.cpu_stall, bus.dma_xfer});
            end
            step();
        end
        bus.cpu_enable = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.dma_xfer, bus.cpu_stall, bus.mem_enable, bus.mem_r_wb, bus.mem_addr, bus.mem_wdata} !==
            {4'b1010, 12'h400, 16'h7777}) begin
            err_cnt++;
            $display("FAIL bp_write: got %h expected %h",
                     {bus.dma_xfer, bus.cpu_stall, bus.mem_enable, bus.mem_r_wb, bus.mem_addr, bus.mem_wdata},
                     {4'b1010, 12'h400, 16'h7777});
        end
        step();
        bus.dma_wvalid = 1'b0;
        vec_cnt++;
        if (bus.dma_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_done: got %b expected 1", bus.dma_done);
        end
        step();
        bus.cpu_enable = 1'b1; bus.cpu_addr = 12'h400;
        #1;
        vec_cnt++;
        if (bus.cpu_rdata !== 16'h7777) begin
            err_cnt++;
            $display("FAIL bp_readback: got %h expected 7777", bus.cpu_rdata);
        end
        step();
        bus.cpu_enable = 1'b0;
    endtask

    task automatic test_wrap_zero();
        logic [11:0] ea [3] = '{12'hFFE, 12'hFFF, 12'h000};
        logic [15:0] ed [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        start_dma(1'b1, 12'hFFE, 8'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if ({bus.dma_xfer, bus.mem_addr, bus.dma_rdata} !== {1'b1, ea[i], ed[i]}) begin
                err_cnt++;
                $display("FAIL wrap_word%0d: got %h expected %h", i,
                         {bus.dma_xfer, bus.mem_addr, bus.dma_rdata}, {1'b1, ea[i], ed[i]});
            end
            step();
        end
        vec_cnt++;
        if (bus.dma_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap_done: got %b expected 1", bus.dma_done);
        end
        step();
        bus.dma_start = 1'b1; bus.dma_r_wb = 1'b1; bus.dma_base = 12'h123; bus.dma_len = 8'd0;
        #1;
        vec_cnt++;
        if (bus.mem_enable !== 1'b0) begin
            err_cnt++;
            $display("FAIL zlen_start: got %b expected 0", bus.mem_enable);
        end
        step();
        bus.dma_start = 1'b0;
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy, bus.dma_xfer, bus.mem_enable} !== 4'b1000) begin
            err_cnt++;
            $display("FAIL zlen_done: got %b expected 1000",
                     {bus.dma_done, bus.dma_busy, bus.dma_xfer, bus.mem_enable});
        end
        step();
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL zlen_after: got %b expected 00", {bus.dma_done, bus.dma_busy});
        end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] ea [3] = '{12'h010, 12'h011, 12'h012};
        start_dma(1'b1, 12'h010, 8'd3);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                bus.dma_start = 1'b1; bus.dma_r_wb = 1'b0; bus.dma_base = 12'h500; bus.dma_len = 8'd5;
            end else begin
                bus.dma_start = 1'b0;
            end
            #1;
            vec_cnt++;
            if ({bus.dma_xfer, bus.mem_r_wb, bus.mem_addr} !== {2'b11, ea[i]}) begin
                err_cnt++;
                $display("FAIL busy_start_word%0d: got %h expected %h", i,
                         {bus.dma_xfer, bus.mem_r_wb, bus.mem_addr}, {2'b11, ea[i]});
            end
            step();
        end
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy} !== 2'b10) begin
            err_cnt++;
            $display("FAIL busy_start_done: got %b expected 10", {bus.dma_done, bus.dma_busy});
        end
        step();
        vec_cnt++;
        if ({bus.dma_done, bus.dma_busy, bus.mem_enable} !== 3'b000) begin
            err_cnt++;
            $display("FAIL busy_start_after: got %b expected 000", {bus.dma_done, bus.dma_busy, bus.mem_enable});
        end
    endtask

    task automatic test_reset_mid_transfer();
        start_dma(1'b1, 12'h010, 8'd10);
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if ({bus.dma_xfer, bus.mem_addr} !== {1'b1, 12'h010 + 12'(i)}) begin
                err_cnt++;
                $display("FAIL rst_mid_word%0d: got %h expected %h", i,
                         {bus.dma_xfer, bus.mem_addr}, {1'b1, 12'h010 + 12'(i)});
            end
            step();
        end
        glb_clr = 1'b1;
        bus.dma_start = 1'b1; bus.dma_base = 12'h020; bus.dma_len = 8'd4;
        step();
        glb_clr = 1'b0;
        bus.dma_start = 1'b0;
        bus.cpu_enable = 1'b1; bus.cpu_r_wb = 1'b1; bus.cpu_addr = 12'h011;
        #1;
        vec_cnt++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.cpu_stall} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rst_mid_flags: got %b expected 0000",
                     {bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.cpu_stall});
        end
        vec_cnt++;
        if ({bus.mem_enable, bus.mem_addr, bus.cpu_rdata} !== {1'b1, 12'h011, 16'h2222}) begin
            err_cnt++;
            $display("FAIL rst_mid_cpu: got %h expected %h",
                     {bus.mem_enable, bus.mem_addr, bus.cpu_rdata}, {1'b1, 12'h011, 16'h2222});
        end
        step();
        bus.cpu_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if ({bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.mem_enable} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL rst_mid_quiet%0d: got %b expected 0000", i,
                         {bus.dma_busy, bus.dma_done, bus.dma_xfer, bus.mem_enable});
            end
            step();
        end
    endtask

    initial begin
        glb_clr = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_passthrough();
        test_idle_dma_read();
        test_starvation();
        test_backpressure();
        test_wrap_zero();
        test_start_while_busy();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_cycle_arbiter.md
Name: mem_cycle_arbiter

Overview:
- Shares the single-port main memory (4096 x 16) between the CPU control unit and a block-transfer DMA channel.
- The CPU always wins a cycle in which it drives a memory strobe. DMA transfers one word per idle memory cycle (cycle stealing).
- A starvation counter forces one DMA cycle by stalling the CPU sequencer.
- Sits between the control unit's r_wb/enable strobes and the memory macro.

Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 16, memory word width
- LEN_W, 8, DMA length field width (max 255 words per transfer)
- STARVE_LIMIT, 4, consecutive DMA-denied cycles before the CPU is stalled for one cycle

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- glb_clr  in  1  reset: synchronous, active-high; same global clear as the rest of the processor
- cpu_enable  in  1  CPU memory strobe (control unit enable)
- cpu_r_wb  in  1  CPU direction: 1 read, 0 write
- cpu_addr  in  ADDR_W  CPU address (AR)
- cpu_wdata  in  DATA_W  CPU write data (data bus)
- cpu_rdata  out  DATA_W  read data returned to the CPU data bus
- cpu_stall  out  1  freezes the CPU sequencer for this cycle
- dma_start  in  1  single-cycle request to begin a transfer
- dma_r_wb  in  1  1: memory-to-device, 0: device-to-memory; sampled at start
- dma_base  in  ADDR_W  first address; sampled at start
- dma_len  in  LEN_W  word count; sampled at start
- dma_wdata  in  DATA_W  device word to write
- dma_wvalid  in  1  dma_wdata is valid
- dma_rdata  out  DATA_W  word read for the device
- dma_xfer  out  1  a DMA word moves this cycle
- dma_busy  out  1  a transfer is in progress
- dma_done  out  1  one-cycle pulse after the last word
- mem_enable  out  1  memory strobe
- mem_r_wb  out  1  memory direction
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (asynchronous read, write on clock edge)

Behaviour:
- Reset (glb_clr=1 at an edge):
  - State returns to IDLE; address, count and starvation counters clear to 0.
  - Outputs: dma_busy=0, dma_done=0, cpu_stall=0, dma_xfer=0.
  - mem_enable follows cpu_enable only (CPU pass-through), so the boot fetch is unaffected.
  - A transfer in progress is aborted with no dma_done pulse.
- States: IDLE, XFER, DONE.
- IDLE:
  - dma_start=1 latches dir/base/len, clears the starvation counter and moves to XFER.
  - If len=0, move to DONE instead.
- XFER, per cycle:
  - DMA is ready when dma_r_wb=1, or when dma_r_wb=0 and dma_wvalid=1.
  - CPU mode (cpu_enable=1 and starve < STARVE_LIMIT):
    - mem_* driven from cpu_*; cpu_stall=0.
    - If DMA is ready, starve increments (saturating).
  - Forced DMA mode (cpu_enable=1, starve = STARVE_LIMIT, DMA ready):
    - cpu_stall=1; the memory cycle goes to DMA; starve resets to 0.
  - Idle cycle (cpu_enable=0 and DMA ready): the cycle goes to DMA.
  - A DMA cycle asserts dma_xfer=1, increments the address, and decrements the count. On a read, dma_rdata=mem_rdata.
  - Address wraps from 0xFFF to 0x000.
  - When the count reaches 0 after a DMA cycle, move to DONE.
  - If DMA is not ready, the CPU passes through, starve is held, and cpu_stall=0.
- DONE: dma_done=1 for exactly one cycle, then IDLE. dma_busy=1 in XFER only.
- dma_start outside IDLE is ignored, with no error.
- Cycle timing and data paths:
  - cpu_stall is combinational in the same cycle.
  - The CPU re-presents the same strobe on the next cycle, so the granted CPU access completes one cycle later.
  - cpu_rdata = mem_rdata whenever the CPU owns the cycle; otherwise 0.
  - mem_enable=0 when neither side owns the cycle.
  - Write latency: the word is in memory at the clock edge ending its granted cycle.
- Simultaneous glb_clr and dma_start: reset wins.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE=2'b00, XFER=2'b01, DONE=2'b10;
  - owner enum OWN_NONE/OWN_CPU/OWN_DMA.
- Optional sub-module dma_addr_counter: loadable address register with wrap, plus down-counter with zero flag.
- Arbitration and muxing stay in the top module.

Test Plan:
- Reset mid-transfer: start len=10, assert glb_clr after 3 words -> busy=0, no done pulse, counters 0, the next CPU read passes through in the same cycle.
- Idle-memory DMA read: cpu_enable=0, start base=0x010, len=3 -> dma_xfer on 3 consecutive cycles, addresses 0x010/0x011/0x012, dma_done one cycle after the third word.
- Starvation: cpu_enable held 1, DMA write len=2 with wvalid=1 -> 4 CPU cycles, then cpu_stall=1 with a DMA write; repeated once more; done after 10 cycles.
- Write back-pressure: wvalid=0 for 5 cycles with cpu_enable=1 -> no stall, starve held at 0; once wvalid=1 the word is written on the next idle cycle.
- Wrap and zero length: base=0xFFE, len=3 -> addresses 0xFFE, 0xFFF, 0x000; separately len=0 -> done pulse one cycle after start with no memory access.
- Start while busy: second dma_start during XFER with a different base -> ignored; the original transfer completes unchanged.
